i2c_sht_target: RTL
===================

# i2c_sht_target

I2C target (responder) matching the team's SHT40-style I2C master: it decodes START/STOP, matches a 7-bit address, ACKs and captures write (command) bytes, and serialises read bytes onto SDA with open-drain semantics. It is used as a synthesizable peripheral model on the same bus as the master, for loopback bring-up and for verifying the master against a cycle-accurate responder.

## Interface
- TARGET_ADDR, 7'h44, 7-bit address this block responds to.
- SYNC_STAGES, 2, synchroniser depth on SCL/SDA inputs (≥2).
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- Scl_In  in  1  raw SCL level from pad.
- Sda_In  in  1  raw SDA level from pad (resolved bus value).
- Sda_Drive_Low  out  1  1 = pull SDA low, 0 = release (high-Z); never drives high.
- Cmd_Data  out  8  last byte written by master; holds until next write byte.
- Cmd_Valid  out  1  one-cycle pulse when Cmd_Data updates.
- Tx_Byte  in  8  next read byte; sampled at start of each read byte.
- Tx_Next  out  1  one-cycle pulse: Tx_Byte consumed, present next byte.
- Busy  out  1  high from address match until STOP/START/abort.
- Read_Active  out  1  high while an addressed read transaction is in progress.
- Nack_Seen  out  1  one-cycle pulse when master NACKs a read byte.

## Operation
- SCL/SDA pass SYNC_STAGES flops; edges detected on synchronised values (previous vs current).
- START: SDA falls while SCL high. STOP: SDA rises while SCL high. Both are detected in every state and take priority over bit handling.
- States: IDLE, ADDR, ADDR_ACK, RX_BYTE, RX_ACK, TX_BYTE, TX_ACK, WAIT_STOP.
- IDLE → ADDR on START. Repeated START from any state → ADDR (bit counter cleared, Sda_Drive_Low released).
- ADDR: shift 8 bits MSB-first on SCL rising edges. After 8th bit: match [7:1]==TARGET_ADDR → ADDR_ACK; mismatch → WAIT_STOP.
- ADDR_ACK: on next SCL falling edge assert Sda_Drive_Low; release on following falling edge; R/W=0 → RX_BYTE, R/W=1 → TX_BYTE (Tx_Byte latched, Tx_Next pulse).
- RX_BYTE: 8 bits shifted on rising edges; then Cmd_Data/Cmd_Valid update and → RX_ACK (ACK driven as in ADDR_ACK) → RX_BYTE.
- TX_BYTE: on each SCL falling edge present next bit MSB-first (Sda_Drive_Low = ~bit); after 8 bits release SDA on falling edge → TX_ACK.
- TX_ACK: sample SDA on SCL rising edge. 0 (ACK) → next byte latched, Tx_Next pulse, → TX_BYTE. 1 (NACK) → Nack_Seen pulse, → WAIT_STOP.
- WAIT_STOP: SDA released; exit only on START (→ ADDR) or STOP (→ IDLE).
- STOP in any state → IDLE; Busy, Read_Active cleared same cycle.

## Timing
- Reset values: Sda_Drive_Low=0, Cmd_Data=8'h00, Cmd_Valid=0, Tx_Next=0, Busy=0, Read_Active=0, Nack_Seen=0, state IDLE.
- Input-to-detection latency: SYNC_STAGES+1 clk cycles after pad change.
- Sda_Drive_Low changes exactly 1 clk after the synchronised SCL falling edge is detected; never while synchronised SCL is high.
- Cmd_Valid asserted 1 clk after the 8th data-bit rising edge.
- Tx_Byte must be stable from Tx_Next until the next synchronised SCL falling edge (≥ one SCL low phase, ≥20 clk with team master).
- Reset asserted mid-transfer: SDA released immediately (async), block in IDLE; bus recovers on next START.

## Configuration
- I2C_TARGET_CRC_EN defined: after every 2 data bytes the block inserts a CRC-8 byte (poly 0x31, init 0xFF, no reflection, no final XOR) computed over those 2 bytes; no Tx_Next pulse for CRC bytes; CRC state resets at each START.
- Undefined: every read byte comes from Tx_Byte; no CRC logic present.

## Structure
- Shared package i2c_pkg: state enum, CRC8_POLY=8'h31, CRC8_INIT=8'hFF, SHT40 default address 7'h44.
- Sub-module sht_crc8: bytewise CRC-8 (clear, byte-valid, 8-bit data in, 8-bit CRC out); instantiated only under I2C_TARGET_CRC_EN.

## Test plan
- Write 0x88(addr 0x44,W), 0xFD, STOP → ACK on both bytes, Cmd_Valid once with Cmd_Data=0xFD, Busy low after STOP.
- Address 0x45 write → no ACK (SDA high at 9th clock), no Cmd_Valid, WAIT_STOP until STOP.
- Read 0x89, Tx_Byte sequence 0x12,0x34,0x56,0x78,0x9A,0xBC, master ACKs 5, NACKs last (CRC off) → bus bytes match, 6 Tx_Next pulses, one Nack_Seen.
- Repeated START after 3 bits of write byte → returns to ADDR, partial byte discarded, no Cmd_Valid; following address match ACKed.
- I2C_TARGET_CRC_EN, read with Tx_Byte 0xBE,0xEF → bus bytes 0xBE,0xEF,0x92; only 2 Tx_Next pulses for those 3 bytes.
- rst_n low while driving ACK → Sda_Drive_Low 0 asynchronously, all outputs at reset values.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared I2C target definitions: FSM state encoding, SHT40 CRC-8 constants
// and a bytewise CRC-8 helper used by sht_crc8.
package i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_RX_BYTE,
        ST_RX_ACK,
        ST_TX_BYTE,
        ST_TX_ACK,
        ST_WAIT_STOP
    } i2c_state_e;

    localparam logic [7:0] CRC8_POLY  = 8'h31;
    localparam logic [7:0] CRC8_INIT  = 8'hFF;
    localparam logic [6:0] SHT40_ADDR = 7'h44;

    // MSB-first, non-reflected CRC-8 over one byte, no final XOR.
    function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ({c[6:0], 1'b0} ^ CRC8_POLY) : {c[6:0], 1'b0};
        end
        return c;
    endfunction

endpackage

// File: rtl/sht_crc8.sv
// Bytewise CRC-8 accumulator (SHT4x flavour): clear reloads the init value,
// byte_vld folds one byte into the running CRC.
module sht_crc8
    import i2c_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       byte_vld,
    input  logic [7:0] data_in,
    output logic [7:0] crc_out
);

    logic [7:0] crc_q, crc_d;

    always_comb begin
        crc_d = crc_q;
        if (clr) begin
            crc_d = CRC8_INIT;
        end else if (byte_vld) begin
            crc_d = crc8_byte(crc_q, data_in);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_q <= CRC8_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_out = crc_q;

endmodule

// File: rtl/i2c_sht_target.sv
// I2C target responder for the SHT40-style master: START/STOP decode, address
// match, write capture and open-drain read serialisation. Define
// I2C_TARGET_CRC_EN to append a CRC-8 byte after every two read data bytes.
module i2c_sht_target
    import i2c_pkg::*;
#(
    parameter logic [6:0] TARGET_ADDR = SHT40_ADDR,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       Scl_In,
    input  logic       Sda_In,
    output logic       Sda_Drive_Low,
    output logic [7:0] Cmd_Data,
    output logic       Cmd_Valid,
    input  logic [7:0] Tx_Byte,
    output logic       Tx_Next,
    output logic       Busy,
    output logic       Read_Active,
    output logic       Nack_Seen
);

    logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
    logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
    logic                   scl_prev_q, sda_prev_q;
    logic                   scl_s, sda_s;
    logic                   scl_rise, scl_fall, start_det, stop_det;

    i2c_state_e state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] sh_q, sh_d;
    logic [7:0] tx_sh_q, tx_sh_d;
    logic       rw_q, rw_d;
    logic       ack_on_q, ack_on_d;
    logic       sda_low_q, sda_low_d;
    logic [7:0] cmd_data_q, cmd_data_d;
    logic       cmd_valid_q, cmd_valid_d;
    logic       tx_next_q, tx_next_d;
    logic       busy_q, busy_d;
    logic       rd_act_q, rd_act_d;
    logic       nack_q, nack_d;
    logic [7:0] shifted;
    logic [7:0] next_byte;
    logic       load;

    assign scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], Scl_In};
    assign sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], Sda_In};
    assign scl_s      = scl_sync_q[SYNC_STAGES-1];
    assign sda_s      = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise   = scl_s & ~scl_prev_q;
    assign scl_fall   = ~scl_s & scl_prev_q;
    assign start_det  = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_det   = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
    assign shifted    = {sh_q[6:0], sda_s};

`ifdef I2C_TARGET_CRC_EN
    logic [1:0] phase_q, phase_d;
    logic       crc_clr, crc_vld;
    logic [7:0] crc_val;

    sht_crc8 u_crc (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (crc_clr),
        .byte_vld (crc_vld),
        .data_in  (Tx_Byte),
        .crc_out  (crc_val)
    );

    // Third byte of each group is the CRC of the two data bytes before it.
    assign next_byte = (phase_q == 2'd2) ? crc_val : Tx_Byte;
`else
    assign next_byte = Tx_Byte;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sh_d        = sh_q;
        tx_sh_d     = tx_sh_q;
        rw_d        = rw_q;
        ack_on_d    = ack_on_q;
        sda_low_d   = sda_low_q;
        cmd_data_d  = cmd_data_q;
        cmd_valid_d = 1'b0;
        tx_next_d   = 1'b0;
        busy_d      = busy_q;
        rd_act_d    = rd_act_q;
        nack_d      = 1'b0;
        load        = 1'b0;
`ifdef I2C_TARGET_CRC_EN
        phase_d     = phase_q;
        crc_clr     = 1'b0;
        crc_vld     = 1'b0;
`endif

        if (stop_det) begin
            state_d   = ST_IDLE;
            cnt_d     = '0;
            ack_on_d  = 1'b0;
            sda_low_d = 1'b0;
            busy_d    = 1'b0;
            rd_act_d  = 1'b0;
        end else if (start_det) begin
            state_d   = ST_ADDR;
            cnt_d     = '0;
            ack_on_d  = 1'b0;
            sda_low_d = 1'b0;
            busy_d    = 1'b0;
            rd_act_d  = 1'b0;
`ifdef I2C_TARGET_CRC_EN
            phase_d   = '0;
            crc_clr   = 1'b1;
`endif
        end else begin
            case (state_q)
                ST_ADDR: begin
                    if (scl_rise) begin
                        sh_d  = shifted;
                        cnt_d = cnt_q + 4'd1;
                        if (cnt_q == 4'd7) begin
                            cnt_d = '0;
                            if (shifted[7:1] == TARGET_ADDR) begin
                                state_d  = ST_ADDR_ACK;
                                rw_d     = shifted[0];
                                busy_d   = 1'b1;
                                rd_act_d = shifted[0];
                            end else begin
                                state_d = ST_WAIT_STOP;
                            end
                        end
                    end
                end
                ST_ADDR_ACK, ST_RX_ACK: begin
                    if (scl_fall) begin
                        if (!ack_on_q) begin
                            sda_low_d = 1'b1;
                            ack_on_d  = 1'b1;
                        end else if (state_q == ST_ADDR_ACK && rw_q) begin
                            // The ACK-ending fall is also where read bit 7 must appear.
                            ack_on_d  = 1'b0;
                            load      = 1'b1;
                            sda_low_d = ~next_byte[7];
                            tx_sh_d   = {next_byte[6:0], 1'b0};
                            cnt_d     = 4'd1;
                            state_d   = ST_TX_BYTE;
                        end else begin
                            ack_on_d  = 1'b0;
                            sda_low_d = 1'b0;
                            cnt_d     = '0;
                            state_d   = ST_RX_BYTE;
                        end
                    end
                end
                ST_RX_BYTE: begin
                    if (scl_rise) begin
                        sh_d  = shifted;
                        cnt_d = cnt_q + 4'd1;
                        if (cnt_q == 4'd7) begin
                            cnt_d       = '0;
                            cmd_data_d  = shifted;
                            cmd_valid_d = 1'b1;
                            state_d     = ST_RX_ACK;
                        end
                    end
                end
                ST_TX_BYTE: begin
                    if (scl_fall) begin
                        if (cnt_q == 4'd8) begin
                            sda_low_d = 1'b0;
                            cnt_d     = '0;
                            state_d   = ST_TX_ACK;
                        end else begin
                            sda_low_d = ~tx_sh_q[7];
                            tx_sh_d   = {tx_sh_q[6:0], 1'b0};
                            cnt_d     = cnt_q + 4'd1;
                        end
                    end
                end
                ST_TX_ACK: begin
                    if (scl_rise) begin
                        if (!sda_s) begin
                            load    = 1'b1;
                            tx_sh_d = next_byte;
                            cnt_d   = '0;
                            state_d = ST_TX_BYTE;
                        end else begin
                            nack_d   = 1'b1;
                            busy_d   = 1'b0;
                            rd_act_d = 1'b0;
                            state_d  = ST_WAIT_STOP;
                        end
                    end
                end
                ST_WAIT_STOP: begin
                    sda_low_d = 1'b0;
                end
                default: begin
                    sda_low_d = 1'b0;
                end
            endcase
        end

        if (load) begin
`ifdef I2C_TARGET_CRC_EN
            if (phase_q == 2'd2) begin
                phase_d = '0;
                crc_clr = 1'b1;
            end else begin
                phase_d   = phase_q + 2'd1;
                crc_vld   = 1'b1;
                tx_next_d = 1'b1;
            end
`else
            tx_next_d = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync_q  <= '1;
            sda_sync_q  <= '1;
            scl_prev_q  <= 1'b1;
            sda_prev_q  <= 1'b1;
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            sh_q        <= '0;
            tx_sh_q     <= '0;
            rw_q        <= 1'b0;
            ack_on_q    <= 1'b0;
            sda_low_q   <= 1'b0;
            cmd_data_q  <= '0;
            cmd_valid_q <= 1'b0;
            tx_next_q   <= 1'b0;
            busy_q      <= 1'b0;
            rd_act_q    <= 1'b0;
            nack_q      <= 1'b0;
        end else begin
            scl_sync_q  <= scl_sync_d;
            sda_sync_q  <= sda_sync_d;
            scl_prev_q  <= scl_s;
            sda_prev_q  <= sda_s;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sh_q        <= sh_d;
            tx_sh_q     <= tx_sh_d;
            rw_q        <= rw_d;
            ack_on_q    <= ack_on_d;
            sda_low_q   <= sda_low_d;
            cmd_data_q  <= cmd_data_d;
            cmd_valid_q <= cmd_valid_d;
            tx_next_q   <= tx_next_d;
            busy_q      <= busy_d;
            rd_act_q    <= rd_act_d;
            nack_q      <= nack_d;
        end
    end

`ifdef I2C_TARGET_CRC_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_d;
        end
    end
`endif

    assign Sda_Drive_Low = sda_low_q;
    assign Cmd_Data      = cmd_data_q;
    assign Cmd_Valid     = cmd_valid_q;
    assign Tx_Next       = tx_next_q;
    assign Busy          = busy_q;
    assign Read_Active   = rd_act_q;
    assign Nack_Seen     = nack_q;

endmodule
